// File: rtl/divider_pkg.sv
// Shared constants, state encoding and helpers for the sequential divider.
// The negate helper is also used by the combinational multiplier.
package divider_pkg;

  localparam int DIV_WIDTH = 64;
  localparam int CNT_W     = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    ZERO = 2'd3
  } div_state_t;

  // Two's-complement negate; the negation of MIN is MIN, which also reads as the magnitude 2^63.
  function automatic logic [DIV_WIDTH-1:0] negate(input logic [DIV_WIDTH-1:0] value);
    return ~value + DIV_WIDTH'(1);
  endfunction

endpackage

// File: rtl/divider.sv
// Sequential restoring divider: one quotient bit per cycle, sign-magnitude
// around an unsigned core, registered results with a one-cycle done pulse.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_t       state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             neg_q, neg_r;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] step_rem, step_quo;

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dvs_neg = is_signed & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? negate(dividend) : dividend;
  assign dvs_mag = dvs_neg ? negate(divisor) : divisor;

  // One restoring step. The partial remainder stays below dvs, so the
  // subtraction is exact in WIDTH bits; bit WIDTH only matters for the compare.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    step_rem = shifted[WIDTH-1:0];
    step_quo = {quo[WIDTH-2:0], 1'b0};
    if (shifted >= {1'b0, dvs}) begin
      step_rem = shifted[WIDTH-1:0] - dvs;
      step_quo = {quo[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = (divisor == '0) ? ZERO : CALC;
      CALC:    if (cnt == LAST_STEP) next_state = SIGN;
      SIGN:    next_state = IDLE;
      ZERO:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // busy decodes the state register only, so it carries no input-to-output path.
  always_comb begin
    busy = (state != IDLE);
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            rem   <= '0;
            dvs   <= dvs_mag;
            neg_q <= dvd_neg ^ dvs_neg;
            neg_r <= dvd_neg;
            // The zero path reports the original dividend, so keep it unnegated.
            quo   <= (divisor == '0) ? dividend : dvd_mag;
          end
        end
        CALC: begin
          rem <= step_rem;
          quo <= step_quo;
          cnt <= cnt + CNT_W'(1);
        end
        SIGN: begin
          quotient    <= neg_q ? negate(quo) : quo;
          remainder   <= neg_r ? negate(rem) : rem;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
        end
        ZERO: begin
          quotient    <= '1;
          remainder   <= quo;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed corner cases, timing scenarios and
// random operands against an arithmetic reference model.
module tb_divider;

  logic        clk = 1'b0;
  logic        reset, start, is_signed;
  logic [63:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [63:0] quotient, remainder;

  int errors = 0;
  int checks = 0;

  divider dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] MIN_S = 64'h8000_0000_0000_0000;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference: truncating division, remainder follows the dividend's sign.
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic s,
                                output logic [63:0] q, output logic [63:0] r, output logic z);
    longint sa, sb;
    z = 1'b0;
    if (b == 64'd0) begin
      q = '1; r = a; z = 1'b1;
    end else if (!s) begin
      q = a / b; r = a % b;
    end else if (a == MIN_S && b == '1) begin
      q = MIN_S; r = 64'd0;
    end else begin
      sa = a; sb = b;
      q = sa / sb; r = sa % sb;
    end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Assumes the caller sits just after an edge: this cycle becomes cycle 0.
  // Returns in the done cycle (or after the cycle budget runs out).
  task automatic launch_and_wait(input logic [63:0] a, input logic [63:0] b, input logic s,
                                 input string tag);
    logic [63:0] q_old, r_old, q_exp, r_exp;
    logic        z_exp;
    int          n;
    q_old = quotient; r_old = remainder;
    model(a, b, s, q_exp, r_exp, z_exp);
    start = 1'b1; dividend = a; divisor = b; is_signed = s;
    tick();
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    n = 1;
    check({tag, " busy_c1"}, {63'd0, busy}, 64'd1);
    check({tag, " hold_c1"}, quotient ^ remainder, q_old ^ r_old);
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check({tag, " done"}, {63'd0, done}, 64'd1);
    check({tag, " latency"}, 64'(n), (b == 64'd0) ? 64'd2 : 64'd66);
    check({tag, " busy_at_done"}, {63'd0, busy}, 64'd0);
    check({tag, " quotient"}, quotient, q_exp);
    check({tag, " remainder"}, remainder, r_exp);
    check({tag, " dbz"}, {63'd0, div_by_zero}, {63'd0, z_exp});
  endtask

  task automatic run_div(input logic [63:0] a, input logic [63:0] b, input logic s, input string tag);
    tick();
    launch_and_wait(a, b, s, tag);
  endtask

  initial begin
    logic [63:0] a, b, q_keep, r_keep, q_exp, r_exp;
    logic        s, z_exp;
    int          n_done, done_at;

    reset = 1'b1; start = 1'b1; is_signed = 1'b0; dividend = 64'd9; divisor = 64'd3;
    tick(); tick();
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset quotient", quotient, 64'd0);
    check("reset remainder", remainder, 64'd0);
    check("reset dbz", {63'd0, div_by_zero}, 64'd0);
    start = 1'b0; reset = 1'b0;

    // Directed cases with spec-stated values pinned alongside the model.
    run_div(64'd100, 64'd7, 1'b0, "u100/7");
    check("u100/7 q const", quotient, 64'd14);
    check("u100/7 r const", remainder, 64'd2);
    tick();
    check("done pulse width", {63'd0, done}, 64'd0);
    tick(); tick();
    check("hold quotient", quotient, 64'd14);
    check("hold remainder", remainder, 64'd2);

    run_div(-64'sd100, 64'd7, 1'b1, "s-100/7");
    check("s-100/7 q const", quotient, 64'hFFFF_FFFF_FFFF_FFF2);
    check("s-100/7 r const", remainder, 64'hFFFF_FFFF_FFFF_FFFE);
    run_div(64'd100, -64'sd7, 1'b1, "s100/-7");
    run_div('1, 64'd2, 1'b0, "uFF/2");
    check("uFF/2 q const", quotient, 64'h7FFF_FFFF_FFFF_FFFF);
    run_div('1, 64'd2, 1'b1, "s-1/2");
    check("s-1/2 r const", remainder, '1);
    run_div(64'd5, 64'd0, 1'b0, "u5/0");
    run_div(64'd5, 64'd0, 1'b1, "s5/0");
    check("s5/0 r const", remainder, 64'd5);
    run_div(64'd9, 64'd3, 1'b0, "u9/3");
    run_div(-64'sd5, 64'd0, 1'b1, "s-5/0");
    run_div(MIN_S, '1, 1'b1, "sMIN/-1");
    check("sMIN/-1 q const", quotient, MIN_S);
    run_div(MIN_S, 64'd3, 1'b1, "sMIN/3");

    // Back-to-back: new start in the done cycle itself.
    launch_and_wait(64'd1000, 64'd10, 1'b0, "b2b");

    // Random operands, including small, negative and zero divisors.
    for (int i = 0; i < 24; i++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: b = {$urandom, $urandom};
        1: b = 64'($urandom_range(1, 255));
        2: b = -64'($urandom_range(1, 255));
        3: b = {32'd0, $urandom};
        default: b = (i % 8 == 0) ? 64'd0 : {$urandom, $urandom} >> $urandom_range(1, 62);
      endcase
      s = 1'($urandom_range(0, 1));
      run_div(a, b, s, "rand");
    end

    // Start re-pulsed at cycle 10 must be ignored: one done, first operands.
    tick();
    model(64'd77, 64'd5, 1'b0, q_exp, r_exp, z_exp);
    start = 1'b1; dividend = 64'd77; divisor = 64'd5; is_signed = 1'b0;
    n_done = 0; done_at = 0;
    for (int c = 1; c <= 150; c++) begin
      tick();
      start = (c == 10);
      if (c == 10) begin dividend = 64'd1234; divisor = 64'd0; end
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          done_at = c; q_keep = quotient; r_keep = remainder;
        end
      end
    end
    start = 1'b0;
    check("ignore done count", 64'(n_done), 64'd1);
    check("ignore latency", 64'(done_at), 64'd66);
    check("ignore quotient", q_keep, q_exp);
    check("ignore remainder", r_keep, r_exp);

    // Reset at cycle 30 discards the operation and clears the outputs.
    tick();
    start = 1'b1; dividend = 64'd999; divisor = 64'd4; is_signed = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      start = 1'b0;
    end
    reset = 1'b1;
    tick();
    check("midreset busy", {63'd0, busy}, 64'd0);
    check("midreset done", {63'd0, done}, 64'd0);
    check("midreset quotient", quotient, 64'd0);
    check("midreset remainder", remainder, 64'd0);
    check("midreset dbz", {63'd0, div_by_zero}, 64'd0);
    reset = 1'b0;
    n_done = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (done || busy) n_done++;
    end
    check("midreset no done", 64'(n_done), 64'd0);

    run_div(64'd45, 64'd6, 1'b0, "after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/divider.md
# divider

Sequential 64-bit integer divider, the inverse counterpart of the team's combinational 64-bit multiplier, for the execute stage's DIV/DIVU/REM/REMU path. It accepts a dividend/divisor pair on a start pulse and runs a restoring shift-subtract loop, one quotient bit per cycle. It then returns quotient and remainder with a one-cycle done pulse. Signed mode uses sign-magnitude conversion around an unsigned core, the same approach the multiplier uses.

## Interface
- WIDTH, 64, operand/result width; only 64 is verified
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned
- dividend  input  WIDTH  numerator, sampled with start
- divisor  input  WIDTH  denominator, sampled with start
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  single-cycle pulse; results valid from this cycle
- quotient  output  WIDTH  result quotient
- remainder  output  WIDTH  result remainder
- div_by_zero  output  1  set with done when divisor was 0; held like the results

## Operation
- States:
  - IDLE: if start, latch operands and go to CALC, or to ZERO if divisor == 0.
  - CALC: WIDTH iterations.
  - SIGN: fix result signs, go to IDLE with done.
  - ZERO: go to IDLE with done.
- Signed entry:
  - neg_q = dividend[msb] ^ divisor[msb].
  - neg_r = dividend[msb].
  - Operands with msb set are replaced by their two's complement. The magnitude of MIN is 2^63, which is representable unsigned.
- Unsigned entry: neg_q = neg_r = 0; operands are used as-is.
- CALC step, on a 2*WIDTH+1-bit working register {rem, quo}:
  - Shift left 1.
  - If rem ≥ divisor magnitude, subtract it and set quo[0].
  - A 7-bit counter counts 0..63; exit CALC after the step at count 63.
- SIGN:
  - quotient = neg_q ? −quo : quo.
  - remainder = neg_r ? −rem : rem.
  - This gives truncation toward zero, with the remainder taking the sign of the dividend.
- Divide by zero: quotient = all ones, remainder = dividend (original, unnegated), div_by_zero = 1.
- Overflow (signed MIN / −1) falls out naturally: quotient = 0x8000_0000_0000_0000, remainder = 0. There is no flag.
- quotient, remainder and div_by_zero hold their values until the next accepted start.
  - At acceptance they are not cleared; they update only at done.
- start while busy (not IDLE) is ignored and not queued.
- Reset values: quotient 0, remainder 0, busy 0, done 0, div_by_zero 0, state IDLE, counter 0.

## Timing
- Cycle 0: start high in IDLE, sampled at the end of the cycle.
- Normal path:
  - Cycles 1–64: CALC, busy = 1.
  - Cycle 65: SIGN, busy = 1.
  - Cycle 66: done = 1 and busy = 0; results valid; state is IDLE.
- Zero path: cycle 1 is ZERO with busy = 1; cycle 2 has done = 1, busy = 0, results valid.
- A new start may be asserted in the done cycle itself; it is accepted back-to-back.
- Reset in any cycle, including mid-CALC: on the next edge, all outputs return to their reset values and the in-flight operation is discarded with no done.
- Reset and start together: reset wins.
- done and busy are never high in the same cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package divider_pkg holds:
  - DIV_WIDTH = 64
  - the state enum div_state_t {IDLE, CALC, SIGN, ZERO}
  - the counter width constant
- The 64-bit two's-complement negate is shared with the multiplier and lives in the package as a function.
- Single module; no sub-module. The per-iteration compare/subtract is inline and does not justify a separate instance.

## Test plan
- Unsigned 100 / 7: done exactly 66 cycles after start; quotient 14, remainder 2, div_by_zero 0.
- Signed −100 / 7: quotient 0xFFFF_FFFF_FFFF_FFF2 (−14), remainder 0xFFFF_FFFF_FFFF_FFFE (−2). Signed 100 / −7: quotient −14, remainder 2.
- Unsigned 0xFFFF_FFFF_FFFF_FFFF / 2: quotient 0x7FFF_FFFF_FFFF_FFFF, remainder 1. The same operands signed (−1 / 2): quotient 0, remainder −1.
- 5 / 0 (both modes): done 2 cycles after start; quotient all ones, remainder 5, div_by_zero 1. A following 9 / 3 clears div_by_zero and gives quotient 3, remainder 0.
- Signed 0x8000_0000_0000_0000 / −1: quotient 0x8000_0000_0000_0000, remainder 0, div_by_zero 0.
- Timing checks:
  - Start, then re-pulse start at cycle 10: it is ignored, and only one done appears.
  - Reset at cycle 30 of a divide: busy 0, all outputs 0, no done.
  - A start issued in a done cycle completes 66 cycles later.
